// File: rtl/ccff_bitstream_loader.sv
// Serialises host words MSB-first into a config flop chain; in verify mode it also compares the tail bit against each bit shifted in.
// One word per WAIT_WORD + WORD_W shift cycles; s_ready only in WAIT_WORD, and the chain holds while s_valid is low.
module ccff_bitstream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 20,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int IDX_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic               mode;
    logic [WORD_W-1:0]  shreg;
    logic [IDX_W-1:0]   idx;
    logic               last_bit, last_in_word, mismatch;

    assign last_bit     = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign last_in_word = (idx == IDX_W'(WORD_W - 1));
    assign mismatch     = (ccff_tail != shreg[WORD_W-1]);

    always_ff @(posedge prog_clk) begin
        if (prog_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start)   state_nxt = WAIT_WORD;
            WAIT_WORD: if (s_valid) state_nxt = SHIFT;
            SHIFT: begin
                // Chain length wins over word boundary: leftover bits of the final word are dropped.
                if (last_bit)          state_nxt = DONE;
                else if (last_in_word) state_nxt = WAIT_WORD;
            end
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready       = (state == WAIT_WORD);
        ccff_shift_en = (state == SHIFT);
        done          = (state == DONE);
        busy          = (state != IDLE);
        ccff_head     = shreg[WORD_W-1];
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            mode      <= 1'b0;
            shreg     <= '0;
            idx       <= '0;
            bit_cnt   <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode    <= verify;
                        bit_cnt <= '0;
                        if (verify) begin
                            err       <= 1'b0;
                            err_count <= '0;
                        end
                    end
                end
                WAIT_WORD: begin
                    if (s_valid) begin
                        shreg <= s_data;
                        idx   <= '0;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[WORD_W-2:0], 1'b0};
                    idx     <= idx + IDX_W'(1);
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    // A correct chain of CHAIN_LEN flops returns exactly the bit now entering it.
                    if (mode && mismatch) begin
                        err <= 1'b1;
                        if (err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboarded bench: drivers queue the expected end-of-pass state, a monitor checks it on every done pulse.
module tb_ccff_bitstream_loader;

    logic        prog_clk = 1'b0;
    logic        prog_reset, start, verify, s_valid;
    logic [7:0]  s_data;
    logic        s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, err;
    logic [15:0] err_count, bit_cnt;

    logic [19:0] chain = '0;
    assign ccff_tail = chain[19];

    typedef struct {
        logic [19:0] chain;
        logic        err;
        logic [15:0] errc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   nshift = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(16)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .verify(verify),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
        .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
        .err(err), .err_count(err_count), .bit_cnt(bit_cnt)
    );

    // Behavioural config chain: first bit in ends up at chain[19] after 20 shifts.
    always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[18:0], ccff_head};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge prog_clk) begin
        if (prog_reset) nshift = 0;
        else if (ccff_shift_en) nshift++;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("chain", 32'(chain), 32'(e.chain));
                check("bit_cnt", 32'(bit_cnt), 32'd20);
                check("shift_cycles", 32'(nshift), 32'd20);
                check("err", 32'(err), 32'(e.err));
                check("err_count", 32'(err_count), 32'(e.errc));
                check("busy_in_done", 32'(busy), 32'd1);
            end
            nshift = 0;
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 200 && !s_ready; k++) @(negedge prog_clk);
        if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy; k++) @(negedge prog_clk);
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send_word(input logic [7:0] w);
        wait_ready();
        s_valid = 1'b1;
        s_data  = w;
        @(negedge prog_clk);
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_shift_en"}, 32'(ccff_shift_en), 0);
        check({tag, "_head"}, 32'(ccff_head), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
        check({tag, "_bit_cnt"}, 32'(bit_cnt), 0);
    endtask

    task automatic run_pass(input logic vfy, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int stall, input bit glitch,
                            input logic [19:0] e_chain, input logic e_err, input logic [15:0] e_errc);
        logic [7:0] words[3];
        exp_t e;
        words[0] = w0; words[1] = w1; words[2] = w2;
        e.chain = e_chain; e.err = e_err; e.errc = e_errc;
        exp_q.push_back(e);
        @(negedge prog_clk);
        start = 1'b1; verify = vfy;
        @(negedge prog_clk);
        start = 1'b0; verify = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0 && stall > 0) begin
                wait_ready();
                for (int s = 0; s < stall; s++) begin
                    check("stall_shift_en", 32'(ccff_shift_en), 0);
                    @(negedge prog_clk);
                end
            end
            send_word(words[i]);
            if (glitch && i == 0) begin
                start = 1'b1;
                @(negedge prog_clk);
                start = 1'b0;
            end
        end
        wait_idle();
    endtask

    initial begin
        prog_reset = 1'b1; start = 1'b0; verify = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge prog_clk);
        check_reset_outputs("reset");
        prog_reset = 1'b0;

        run_pass(1'b0, 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 20'hA53CF, 1'b0, 16'd0);
        run_pass(1'b1, 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 20'hA53CF, 1'b0, 16'd0);
        run_pass(1'b0, 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 20'hA53CF, 1'b0, 16'd0);
        run_pass(1'b1, 8'hA5, 8'h3D, 8'hF0, 0, 1'b0, 20'hA53DF, 1'b1, 16'd1);
        // A load pass keeps the sticky verify result from before.
        run_pass(1'b0, 8'hA5, 8'h3C, 8'hF0, 5, 1'b0, 20'hA53CF, 1'b1, 16'd1);

        // Reset in the middle of the second word.
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        send_word(8'hA5);
        send_word(8'h3C);
        for (int k = 0; k < 50 && bit_cnt != 16'd9; k++) @(negedge prog_clk);
        check("reach_bit9", 32'(bit_cnt), 32'd9);
        prog_reset = 1'b1;
        @(negedge prog_clk);
        check_reset_outputs("midreset");
        prog_reset = 1'b0;
        repeat (5) @(negedge prog_clk);
        check("idle_after_reset", 32'(busy), 0);

        run_pass(1'b0, 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 20'hA53CF, 1'b0, 16'd0);
        run_pass(1'b0, 8'h0F, 8'hC3, 8'h5A, 0, 1'b1, 20'h0FC35, 1'b0, 16'd0);

        // start together with reset must leave the loader idle.
        @(negedge prog_clk);
        start = 1'b1; prog_reset = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; prog_reset = 1'b0;
        check("start_rst_busy", 32'(busy), 0);
        check("start_rst_ready", 32'(s_ready), 0);
        @(negedge prog_clk);
        check("start_rst_busy2", 32'(busy), 0);

        repeat (5) @(negedge prog_clk);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
